// File: rtl/pix_pkg.sv
// Shared pixel-record types and image geometry for the frame-buffer write path.
package pix_pkg;

    localparam int unsigned PIX_W      = 24;
    localparam int unsigned PIX_ADDR_W = 16;
    localparam int unsigned IMG_H      = 256;
    localparam int unsigned IMG_V      = 128;
    localparam int unsigned PIX_NUM    = IMG_H * IMG_V;

    typedef struct packed {
        logic [PIX_ADDR_W-1:0] addr;
        logic [PIX_W-1:0]      data;
    } pix_rec_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } pix_state_e;

endpackage

// File: rtl/pix_rec_fifo.sv
// Synchronous pixel-record FIFO; wrap-bit pointers separate full from empty.
module pix_rec_fifo
    import pix_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     wr_en,
    input  pix_rec_t wr_data,
    input  logic     rd_en,
    output pix_rec_t head_c,
    output logic     empty_c,
    output logic     full_c,
    output logic     full_nxt_c
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    pix_rec_t           mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_d;

    assign wr_ptr_d   = wr_ptr_q + PTR_W'(wr_en);
    assign rd_ptr_d   = rd_ptr_q + PTR_W'(rd_en);
    assign head_c     = mem[rd_ptr_q[IDX_W-1:0]];
    assign empty_c    = (wr_ptr_q == rd_ptr_q);
    assign full_c     = ((wr_ptr_q - rd_ptr_q) == PTR_W'(DEPTH));
    // Occupancy after this cycle's push/pop, used to register the input ready
    assign full_nxt_c = ((wr_ptr_d - rd_ptr_d) == PTR_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[IDX_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/pix_wr_ctrl.sv
// Buffers parsed pixel records and writes them to the frame-buffer RAM, counting frames.
// Optional PIX_WR_BOUND_CHK_EN: records addressed beyond the frame are consumed and counted in drop_cnt.
module pix_wr_ctrl
    import pix_pkg::pix_rec_t, pix_pkg::pix_state_e, pix_pkg::ST_IDLE, pix_pkg::ST_WRITE,
           pix_pkg::PIX_ADDR_W, pix_pkg::PIX_W;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PIX_NUM    = pix_pkg::PIX_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rec_valid,
    output logic              rec_ready,
    input  logic [ADDR_W-1:0] rec_addr,
    input  logic [DATA_W-1:0] rec_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic              ram_ready,
    output logic              frame_done,
    input  logic              frame_clr,
`ifdef PIX_WR_BOUND_CHK_EN
    output logic [7:0]        drop_cnt,
`endif
    output logic [ADDR_W-1:0] wr_cnt
);

    pix_state_e state_q;
    pix_state_e state_d;
    pix_rec_t   rec_in_c;
    pix_rec_t   fifo_head_c;
    pix_rec_t   load_rec_c;
    logic       fifo_empty_c;
    logic       fifo_full_c;
    logic       fifo_full_nxt_c;
    logic       keep_c;
    logic       push_c;
    logic       load_c;
    logic       fifo_rd_c;
    logic       fifo_wr_c;
    logic       wr_done_c;
    logic       wr_last_c;

    assign rec_in_c.addr = PIX_ADDR_W'(rec_addr);
    assign rec_in_c.data = PIX_W'(rec_data);

`ifdef PIX_WR_BOUND_CHK_EN
    assign keep_c = (32'(rec_addr) < PIX_NUM);
`else
    assign keep_c = 1'b1;
`endif

    assign push_c     = rec_valid & rec_ready & ~fifo_full_c & keep_c;
    assign fifo_rd_c  = load_c & ~fifo_empty_c;
    // With an empty FIFO the incoming record goes straight to the output register
    assign fifo_wr_c  = push_c & ~(load_c & fifo_empty_c);
    assign load_rec_c = fifo_empty_c ? rec_in_c : fifo_head_c;
    assign wr_done_c  = ram_we & ram_ready;
    assign wr_last_c  = (wr_cnt == ADDR_W'(PIX_NUM - 1));

    pix_rec_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (fifo_wr_c),
        .wr_data    (rec_in_c),
        .rd_en      (fifo_rd_c),
        .head_c     (fifo_head_c),
        .empty_c    (fifo_empty_c),
        .full_c     (fifo_full_c),
        .full_nxt_c (fifo_full_nxt_c)
    );

    // Output FSM: next state and holding-register load
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_c || push_c) begin
                    state_d = ST_WRITE;
                    load_c  = 1'b1;
                end
            end
            ST_WRITE: begin
                if (ram_ready) begin
                    if (!fifo_empty_c || push_c) begin
                        load_c = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            rec_ready  <= 1'b0;
            wr_cnt     <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            ram_we    <= (state_d == ST_WRITE);
            rec_ready <= ~fifo_full_nxt_c;
            if (load_c) begin
                ram_addr <= ADDR_W'(load_rec_c.addr);
                ram_din  <= DATA_W'(load_rec_c.data);
            end
            if (wr_done_c) begin
                wr_cnt <= wr_last_c ? '0 : wr_cnt + ADDR_W'(1);
            end
            // A completion in the same cycle as frame_clr keeps the flag set
            if (wr_done_c && wr_last_c) begin
                frame_done <= 1'b1;
            end else if (frame_clr) begin
                frame_done <= 1'b0;
            end
        end
    end

`ifdef PIX_WR_BOUND_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (rec_valid && rec_ready && !keep_c && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule
